// File: rtl/multicycle_controller.sv
// Main control unit for the multicycle RV32I core: instruction-sequencing FSM
// plus the immediate-format and ALU-operation decoders.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE_R = 4'd6,
    ALU_WB    = 4'd7,
    EXECUTE_I = 4'd8,
    JAL       = 4'd9,
    BEQ       = 4'd10
  } state_t;

  state_t     cur, nxt;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       mem_write_s, ir_write_s, reg_write_s;

  always_ff @(posedge clk) begin
    if (reset) cur <= state_t'(RESET_STATE);
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt         = FETCH;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    case (cur)
      FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
        nxt        = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nxt = MEM_ADR;
          7'b0110011:             nxt = EXECUTE_R;
          7'b0010011:             nxt = EXECUTE_I;
          7'b1101111:             nxt = JAL;
          7'b1100011:             nxt = BEQ;
          default:                nxt = FETCH;
        endcase
      end
      MEM_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt     = (op == 7'b0000011) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        AdrSrc = 1'b1;
        nxt    = MEM_WB;
      end
      MEM_WB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      MEM_WRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTE_R: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        nxt     = ALU_WB;
      end
      ALU_WB: reg_write_s = 1'b1;
      EXECUTE_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        nxt     = ALU_WB;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        nxt       = ALU_WB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Architectural write enables are held off for the whole reset cycle.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign MemWrite = ~reset & mem_write_s;
  assign IRWrite  = ~reset & ir_write_s;
  assign RegWrite = ~reset & reg_write_s;

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the multicycle RV32I core.
- Holds the instruction-sequencing FSM and steers every datapath mux and write enable: PC, instruction register, memory, register file, ALU and immediate extender.
- Supports lw, sw, R-type ALU ops, I-type ALU ops, beq and jal.
- Drives ImmSrc straight to the immediate extender and ALUControl straight to the ALU.

Parameters:
- RESET_STATE, 4'd0, encoding of the state entered on reset (Fetch); must stay 0.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  Instr[6:0] from the instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register / OldPC enable
- ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=RD1 register
- ALUSrcB  output  2  ALU B select: 00=RD2 register, 01=ImmExt, 10=constant 4
- RegWrite  output  1  register file write enable
- ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- state  output  4  current FSM state, for debug and verification

Behaviour:
- State register updates on the rising clk edge. When reset=1 at an edge, the next state is S0 Fetch regardless of the current state, including mid-instruction.
- While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0.
- All other outputs are Moore functions of state, except:
  - ImmSrc and ALUControl: combinational from op/funct.
  - PCWrite: combinational, see below.
- States, their asserted outputs and next state. Unlisted selects are 00/0; unlisted enables are 0.
  - S0 Fetch: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: S1.
  - S1 Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op:
    - 0000011 or 0100011 -> S2
    - 0110011 -> S6
    - 0010011 -> S8
    - 1101111 -> S9
    - 1100011 -> S10
    - any other op -> S0 (illegal opcode is dropped; no write enables asserted)
  - S2 MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: S3 if op=0000011, else S5.
  - S3 MemRead: ResultSrc=00, AdrSrc=1. Next: S4.
  - S4 MemWB: ResultSrc=01, RegWrite=1. Next: S0.
  - S5 MemWrite: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: S0.
  - S6 ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: S7.
  - S7 ALUWB: ResultSrc=00, RegWrite=1. Next: S0.
  - S8 ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: S7.
  - S9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: S7.
  - S10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: S0.
  - Unused encodings 11-15 -> S0, all enables 0.
- PCWrite = PCUpdate | (Branch & zero). zero is sampled combinationally in S10 only.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- ImmSrc decode by op:
  - 0000011, 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other -> 00
- ALUControl decode:
  - ALUOp 00 -> 000
  - ALUOp 01 -> 001
  - ALUOp 10, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other -> 000
- ALUOp is internal (2 bits).
- No output may be X in any reachable state.

Test Plan:
- lw (op=0000011) after reset release:
  - state sequence 0,1,2,3,4,0.
  - IRWrite=1 and PCWrite=1 only in S0; AdrSrc=1 in S3; RegWrite=1 with ResultSrc=01 only in S4; ImmSrc=00 throughout.
- sw (op=0100011):
  - sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle (S5); RegWrite never 1; ImmSrc=01.
- R-type:
  - op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in S6.
  - funct7b5=0 -> 000.
  - funct3=010 -> 101.
  - S7 asserts RegWrite with ResultSrc=00.
- addi with funct7b5=1 (op=0010011, funct3=000, Instr[30]=1): ALUControl=000 in S8 (no sub); sequence 0,1,8,7,0.
- beq (op=1100011): zero=1 in S10 -> PCWrite=1; zero=0 -> PCWrite=0; both return to S0 next cycle; ImmSrc=10.
- Reset and illegal opcode:
  - jal: sequence 0,1,9,7,0 with PCWrite=1 in S9 and ImmSrc=11.
  - Assert reset during S3 of lw: all enables 0 while reset is high; state=0 after the edge; RegWrite never pulses.
  - op=1111111 in S1 -> next state 0, no enables asserted.
